// File: rtl/ov5640_cfg_seq_if.sv
// Start/done handshake between the configuration sequencer and the SCCB master.
interface ov5640_cfg_seq_if;
  logic        start;
  logic [31:0] data;
  logic        busy;
  logic        done;

  modport master (output start, output data, input busy, input done);
  modport slave  (input start, input data, output busy, output done);
endinterface

// File: rtl/ov5640_cfg_seq.sv
// OV5640 register-initialisation sequencer: walks a config table and feeds each
// word to the SCCB master, inserting programmed waits for delay entries.
module ov5640_cfg_seq #(
  parameter logic [19:0] INIT_DELAY = 20'd50000,
  parameter logic [7:0]  REG_NUM    = 8'd250,
  parameter int unsigned IDX_W      = 8,
  parameter logic [15:0] GAP_CYCLES = 16'd16,
  parameter logic [19:0] TIMEOUT    = 20'd200000
) (
  input  logic                 sysclk,
  input  logic                 rst_n,
  input  logic                 reinit,
  output logic [IDX_W-1:0]     lut_index,
  input  logic [31:0]          lut_data,
  ov5640_cfg_seq_if.master     sccb,
  output logic                 cfg_busy,
  output logic                 cfg_done,
  output logic                 cfg_err
);

  localparam int unsigned CNT_W  = 24;
  localparam int unsigned WORD_W = 32;

  typedef enum logic [3:0] {
    PWR_WAIT, FETCH, ISSUE, WAIT_DONE, GAP, DELAY, NEXT, DONE, ERR
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [WORD_W-1:0]  word_q, word_d;
  logic [WORD_W-1:0]  data_q, data_d;
  logic               start_q, start_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  // Shared cycle counter, saturating so long delays never wrap back to short ones
  assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_inc;
    idx_d   = idx_q;
    word_d  = word_q;
    data_d  = data_q;
    start_d = 1'b0;

    case (state_q)
      PWR_WAIT: begin
        if (cnt_inc >= CNT_W'(INIT_DELAY)) begin
          state_d = FETCH;
          cnt_d   = '0;
        end
      end
      // Two cycles with a stable index so a registered ROM has its word ready
      FETCH: begin
        if (cnt_q != '0) begin
          word_d  = lut_data;
          cnt_d   = '0;
          state_d = (lut_data[31:24] == 8'hFF) ? DELAY : ISSUE;
        end
      end
      ISSUE: begin
        cnt_d = '0;
        if (!sccb.busy) begin
          start_d = 1'b1;
          data_d  = word_q;
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (sccb.done) begin
          state_d = GAP;
          cnt_d   = '0;
        end else if ((TIMEOUT != '0) && (cnt_inc >= CNT_W'(TIMEOUT))) begin
          state_d = ERR;
          cnt_d   = '0;
        end
      end
      GAP: begin
        if (cnt_inc >= CNT_W'(GAP_CYCLES)) begin
          state_d = NEXT;
          cnt_d   = '0;
        end
      end
      DELAY: begin
        if (cnt_inc >= word_q[CNT_W-1:0]) begin
          state_d = NEXT;
          cnt_d   = '0;
        end
      end
      NEXT: begin
        cnt_d = '0;
        if (idx_q == IDX_W'(REG_NUM - 8'd1)) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = FETCH;
        end
      end
      DONE, ERR: begin
        cnt_d = '0;
        if (reinit) begin
          idx_d   = '0;
          state_d = PWR_WAIT;
        end
      end
      default: begin
        state_d = PWR_WAIT;
        cnt_d   = '0;
      end
    endcase

    busy_d = !((state_d == DONE) || (state_d == ERR));
    done_d = (state_d == DONE);
    err_d  = (state_d == ERR);
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= PWR_WAIT;
      cnt_q   <= '0;
      idx_q   <= '0;
      word_q  <= '0;
      data_q  <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      data_q  <= data_d;
      start_q <= start_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign lut_index  = idx_q;
  assign sccb.start = start_q;
  assign sccb.data  = data_q;
  assign cfg_busy   = busy_q;
  assign cfg_done   = done_q;
  assign cfg_err    = err_q;

endmodule

// File: tb/tb_ov5640_cfg_seq.sv
// Scoreboard bench for ov5640_cfg_seq: expected SCCB starts (word + cycle) are
// queued by the stimulus and checked by a monitor on every start pulse.
module tb_ov5640_cfg_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        reinit;
  logic        busy;
  logic        model_done;
  logic        stray_done;
  logic [7:0]  lut_index;
  logic [31:0] lut_data;
  logic        cfg_busy, cfg_done, cfg_err;

  logic [31:0] rom [3];
  logic        drop_en;
  logic [31:0] drop_data;
  int          pend;
  logic        busy_edge;
  int          cyc = 0;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ov5640_cfg_seq_if sccb_if ();
  assign sccb_if.busy = busy;
  assign sccb_if.done = model_done | stray_done;

  ov5640_cfg_seq #(
    .INIT_DELAY (20'd10),
    .REG_NUM    (8'd3),
    .IDX_W      (8),
    .GAP_CYCLES (16'd4),
    .TIMEOUT    (20'd200)
  ) dut (
    .sysclk    (clk),
    .rst_n     (rst_n),
    .reinit    (reinit),
    .lut_index (lut_index),
    .lut_data  (lut_data),
    .sccb      (sccb_if.master),
    .cfg_busy  (cfg_busy),
    .cfg_done  (cfg_done),
    .cfg_err   (cfg_err)
  );

  // Registered table ROM
  always @(posedge clk) lut_data <= (lut_index < 8'd3) ? rom[lut_index[1:0]] : 32'h0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // SCCB model: done sampled by the DUT 20 cycles after the start edge
  always @(negedge clk) begin
    if (!rst_n) begin
      pend       = 0;
      model_done = 1'b0;
    end else begin
      model_done = 1'b0;
      if (pend > 0) begin
        pend = pend - 1;
        if (pend == 0) model_done = 1'b1;
      end
      if (sccb_if.start && !(drop_en && (sccb_if.data == drop_data))) pend = 19;
    end
  end

  always @(posedge clk) busy_edge <= busy;

  // Monitor: every start pulse must match the next expected word and cycle
  always @(negedge clk) begin
    if (rst_n && sccb_if.start) begin
      check32("start_vs_busy", 32'(busy_edge), 32'h0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_start: got data %h at cycle %0d, none expected", sccb_if.data, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        check32("start_data", sccb_if.data, mon_e.data);
        check32("start_cycle", 32'(cyc), 32'(mon_e.cyc));
      end
    end
  end

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic pulse_reinit_at(input int c);
    wait_cyc(c);
    reinit = 1'b1;
    wait_cyc(c + 1);
    reinit = 1'b0;
  endtask

  task automatic pulse_done_at(input int c);
    wait_cyc(c);
    stray_done = 1'b1;
    wait_cyc(c + 1);
    stray_done = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check32({tag, "_lut_index"}, 32'(lut_index), 32'h0);
    check32({tag, "_start"}, 32'(sccb_if.start), 32'h0);
    check32({tag, "_data"}, sccb_if.data, 32'h0);
    check32({tag, "_busy"}, 32'(cfg_busy), 32'h0);
    check32({tag, "_done"}, 32'(cfg_done), 32'h0);
    check32({tag, "_err"}, 32'(cfg_err), 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int rel, e;
    rst_n      = 1'b0;
    reinit     = 1'b0;
    busy       = 1'b0;
    stray_done = 1'b0;
    drop_en    = 1'b0;
    drop_data  = 32'h78aa56bb;
    rom[0] = 32'h78300882; rom[1] = 32'hFF000032; rom[2] = 32'h78aa56bb;

    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    rst_n = 1'b1;
    rel   = cyc;

    // Normal walk with stray done in PWR_WAIT and GAP, plus ignored mid-run reinit
    exp_q.push_back('{32'h78300882, rel + 13});
    exp_q.push_back('{32'h78aa56bb, rel + 94});
    wait_cyc(rel + 1);
    check32("busy_after_release", 32'(cfg_busy), 32'h1);
    pulse_done_at(rel + 4);
    pulse_done_at(rel + 34);
    pulse_reinit_at(rel + 59);
    check32("midrun_reinit_idx", 32'(lut_index), 32'h1);
    check32("midrun_reinit_busy", 32'(cfg_busy), 32'h1);
    wait_cyc(rel + 118);
    check32("done_before_end", 32'(cfg_done), 32'h0);
    reinit = 1'b1;
    wait_cyc(rel + 119);
    reinit = 1'b0;
    check32("walk_done", 32'(cfg_done), 32'h1);
    check32("walk_busy", 32'(cfg_busy), 32'h0);
    check32("walk_idx", 32'(lut_index), 32'h2);
    wait_cyc(rel + 125);
    check32("reinit_on_done_entry_ignored", 32'(cfg_done), 32'h1);

    // Reinit from DONE: identical second pass
    pulse_reinit_at(rel + 130);
    e = rel + 131;
    check32("reinit_done_clr", 32'(cfg_done), 32'h0);
    check32("reinit_busy", 32'(cfg_busy), 32'h1);
    check32("reinit_idx", 32'(lut_index), 32'h0);
    exp_q.push_back('{32'h78300882, e + 13});
    exp_q.push_back('{32'h78aa56bb, e + 94});
    wait_cyc(e + 119);
    check32("pass2_done", 32'(cfg_done), 32'h1);
    check32("pass2_idx", 32'(lut_index), 32'h2);

    // Busy back-pressure for 15 cycles on ISSUE entry
    pulse_reinit_at(e + 130);
    e = e + 131;
    exp_q.push_back('{32'h78300882, e + 28});
    exp_q.push_back('{32'h78aa56bb, e + 109});
    wait_cyc(e + 12);
    busy = 1'b1;
    wait_cyc(e + 27);
    busy = 1'b0;
    wait_cyc(e + 134);
    check32("busy_pass_done", 32'(cfg_done), 32'h1);

    // Reset during WAIT_DONE
    pulse_reinit_at(e + 140);
    e = e + 141;
    exp_q.push_back('{32'h78300882, e + 13});
    wait_cyc(e + 13);
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("async_rst");
    rom[0] = 32'h78300882; rom[1] = 32'h78aa56bb; rom[2] = 32'h78123456;
    wait_cyc(cyc + 3);
    rst_n = 1'b1;
    rel   = cyc;

    // Timeout on entry 1, then reinit from ERR
    drop_en = 1'b1;
    exp_q.push_back('{32'h78300882, rel + 13});
    exp_q.push_back('{32'h78aa56bb, rel + 41});
    wait_cyc(rel + 240);
    check32("err_before_timeout", 32'(cfg_err), 32'h0);
    check32("busy_before_timeout", 32'(cfg_busy), 32'h1);
    wait_cyc(rel + 241);
    check32("timeout_err", 32'(cfg_err), 32'h1);
    check32("timeout_busy", 32'(cfg_busy), 32'h0);
    check32("timeout_idx", 32'(lut_index), 32'h1);
    wait_cyc(rel + 250);
    check32("err_idx_frozen", 32'(lut_index), 32'h1);
    check32("err_held", 32'(cfg_err), 32'h1);
    reinit = 1'b1;
    wait_cyc(rel + 251);
    reinit = 1'b0;
    e = cyc;
    drop_en = 1'b0;
    check32("err_cleared", 32'(cfg_err), 32'h0);
    check32("err_reinit_idx", 32'(lut_index), 32'h0);
    check32("err_reinit_busy", 32'(cfg_busy), 32'h1);
    exp_q.push_back('{32'h78300882, e + 13});
    exp_q.push_back('{32'h78aa56bb, e + 41});
    exp_q.push_back('{32'h78123456, e + 69});
    wait_cyc(e + 94);
    check32("rerun_done", 32'(cfg_done), 32'h1);

    // Done coincident with the timeout cycle: GAP wins over ERR
    pulse_reinit_at(e + 100);
    e = e + 101;
    drop_en = 1'b1;
    exp_q.push_back('{32'h78300882, e + 13});
    exp_q.push_back('{32'h78aa56bb, e + 41});
    exp_q.push_back('{32'h78123456, e + 249});
    pulse_done_at(e + 240);
    check32("coincident_no_err", 32'(cfg_err), 32'h0);
    check32("coincident_busy", 32'(cfg_busy), 32'h1);
    wait_cyc(e + 242);
    check32("coincident_no_err_later", 32'(cfg_err), 32'h0);
    wait_cyc(e + 273);
    check32("coincident_not_done_yet", 32'(cfg_done), 32'h0);
    wait_cyc(e + 274);
    check32("coincident_done", 32'(cfg_done), 32'h1);
    check32("coincident_final_err", 32'(cfg_err), 32'h0);
    drop_en = 1'b0;

    wait_cyc(cyc + 30);
    check32("scoreboard_drained", 32'(exp_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
